mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have these ports, one per line, clock and reset first.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- mem_rd  in  1  MEM-stage load request.
- mem_wr  in  1  MEM-stage store request.
- funct3  in  3  access size/sign.
- addr  in  32  byte address from ALUOut.
- wdata  in  32  store data, rs2.
- bus_req  out  1  data-bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word-aligned bus address, bits [1:0]=0.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte strobes.
- bus_ack  in  1  bus completion, one-cycle pulse.
- bus_rdata  in  32  bus read word, valid with bus_ack.
- DRAMRd  out  32  formatted load data to the write-back mux.
- mem_stall  out  1  freeze pipeline.
- mem_done  out  1  one-cycle access-complete pulse.
- misalign  out  1  misaligned-access pulse (see REQ-019).

Function
REQ-002 The FSM SHALL have states IDLE, BUS, DONE; reset state IDLE.
REQ-003 In IDLE with mem_rd or mem_wr high, the block SHALL latch addr, funct3, wdata and direction, and move to BUS next cycle.
REQ-004 If mem_rd and mem_wr are both high, it SHALL treat the access as a load.
REQ-005 In BUS, bus_req SHALL be 1 and bus_addr/bus_we/bus_wdata/bus_wstrb SHALL hold the latched values until the cycle bus_ack is sampled high.
REQ-006 On bus_ack in BUS, the FSM SHALL go to DONE, and for loads DRAMRd SHALL register the formatted bus_rdata.
REQ-007 A bus_ack seen in IDLE or DONE SHALL be ignored.
REQ-008 DONE SHALL last one cycle with mem_done=1 and mem_stall=0, ignoring mem_rd/mem_wr, then go to IDLE.
REQ-009 mem_stall SHALL be combinational: 1 in BUS, 1 in IDLE when mem_rd|mem_wr, else 0.
REQ-010 Minimum latency SHALL be 3 cycles: request cycle, BUS with ack, DONE.
REQ-011 Load formatting, with byte lane addr[1:0] and halfword lane addr[1]:
- 000 LB: sign-extend.
- 001 LH: sign-extend.
- 100 LBU: zero-extend.
- 101 LHU: zero-extend.
- 010 and all other codes: full word.
REQ-012 Store strobes:
- SB: 0001<<addr[1:0].
- SH: 0011<<{addr[1],0}.
- SW and other codes: 1111.
REQ-013 bus_wdata SHALL replicate the byte (SB) or halfword (SH) across all lanes, and pass the word for SW.
REQ-014 DRAMRd SHALL hold its value until the next completed load; stores SHALL NOT change it.
REQ-015 Outside BUS, bus_req SHALL be 0; bus_we, bus_wstrb and bus_wdata SHALL be 0.

Reset
REQ-016 While rst_n is low, the block SHALL hold state IDLE and drive DRAMRd=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, mem_done=0 and misalign=0.
REQ-017 mem_stall during reset SHALL follow REQ-009 from the inputs.
REQ-018 Reset asserted mid-transaction SHALL abort it immediately; a later bus_ack for the aborted access SHALL be ignored.

Configuration
REQ-019 With MEM_ALIGN_CHECK_EN defined:
- An access is misaligned if it is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- A misaligned access SHALL skip BUS, go IDLE->DONE, pulse misalign with mem_done, and leave DRAMRd unchanged.
REQ-020 Without MEM_ALIGN_CHECK_EN, misalign SHALL be tied 0, and the offending low address bits SHALL be treated as 0 for lane selection.

Verification
REQ-021 LB at addr 0x103, bus_rdata=0x80FF_0000 with ack in the first BUS cycle: DRAMRd=0xFFFFFF80, bus_addr=0x100, mem_done pulses in cycle 3.
REQ-022 LHU at addr 0x102, rdata=0xBEEF1234, ack delayed 4 BUS cycles: mem_stall=1 for 5 cycles, then DRAMRd=0x0000BEEF.
REQ-023 SB at addr 0x201, wdata=0x000000AB: bus_we=1, bus_wstrb=0010, bus_wdata=0xABABABAB, and DRAMRd is unchanged.
REQ-024 rst_n is pulled low in BUS and released, then a stray bus_ack arrives: the block stays in IDLE, bus_req=0, and mem_done does not pulse.
REQ-025 LW at addr 0x302 with MEM_ALIGN_CHECK_EN: bus_req is never asserted, and misalign and mem_done pulse together in cycle 2. Without the macro: bus_addr=0x300 and a normal load completes.
REQ-026 mem_rd and mem_wr are both high: the access is a load with bus_we=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer onto a single-word data bus with ack handshake.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses skip the bus and pulse misalign.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] DRAMRd,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, dram_q;
    logic [2:0]  f3_q;
    logic        we_q, mis_q;
    logic        req, req_we, req_mis, in_bus;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ld_fmt, st_wdata;
    logic [3:0]  st_strb;
    logic [1:0]  st_sz;

    // 0 = byte, 1 = halfword, 2 = word; loads x00/x01 are byte/half, stores only 000/001
    function automatic logic [1:0] size_of(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'b000) ? 2'd0 : (f3 == 3'b001) ? 2'd1 : 2'd2;
        return (f3[1:0] == 2'b00) ? 2'd0 : (f3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    endfunction

    assign req    = mem_rd | mem_wr;
    assign req_we = mem_wr & ~mem_rd;

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] req_sz;
    assign req_sz  = size_of(req_we, funct3);
    assign req_mis = (req_sz == 2'd1 && addr[0]) || (req_sz == 2'd2 && addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    assign rb     = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rh     = bus_rdata[{addr_q[1], 4'b0000} +: 16];
    assign ld_fmt = (f3_q == 3'b000) ? {{24{rb[7]}}, rb} :
                    (f3_q == 3'b001) ? {{16{rh[15]}}, rh} :
                    (f3_q == 3'b100) ? {24'd0, rb} :
                    (f3_q == 3'b101) ? {16'd0, rh} : bus_rdata;

    assign st_sz    = size_of(1'b1, f3_q);
    assign st_strb  = (st_sz == 2'd0) ? 4'b0001 << addr_q[1:0] :
                      (st_sz == 2'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign st_wdata = (st_sz == 2'd0) ? {4{wdata_q[7:0]}} :
                      (st_sz == 2'd1) ? {2{wdata_q[15:0]}} : wdata_q;

    assign in_bus    = (state_q == BUS);
    assign bus_req   = in_bus;
    assign bus_we    = in_bus & we_q;
    assign bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_wdata = (in_bus & we_q) ? st_wdata : 32'd0;
    assign bus_wstrb = (in_bus & we_q) ? st_strb : 4'd0;
    assign mem_done  = (state_q == DONE);
    assign misalign  = mem_done & mis_q;
    assign mem_stall = in_bus | ((state_q == IDLE) & req);
    assign DRAMRd    = dram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            dram_q  <= 32'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    addr_q  <= addr;
                    f3_q    <= funct3;
                    wdata_q <= wdata;
                    we_q    <= req_we;
                    mis_q   <= req_mis;
                    state_q <= req_mis ? DONE : BUS;
                end
                BUS: if (bus_ack) begin
                    state_q <= DONE;
                    if (!we_q) dram_q <= ld_fmt;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
